// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module : pwm_pkg
// Shared mode/direction encodings and default sizes for the PWM compare bank.
// Rev    : 1.0
// ============================================================================
package pwm_pkg;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  localparam int DEF_WIDTH    = 7;
  localparam int DEF_CHANNELS = 2;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage
`default_nettype wire

// File: rtl/pwm_ccr_channel.sv
`default_nettype none
// ============================================================================
// Module : pwm_ccr_channel
// One compare channel: shadow/active CCR pair, pending flag and PWM compare.
// Rev    : 1.0
// ============================================================================
module pwm_ccr_channel
  import pwm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_run,
  input  logic [WIDTH-1:0] i_tcr,
  input  logic             i_load,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic             o_pending,
  output logic             o_pwm
);

  logic [WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0] r_active;
  logic             r_pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow  <= '0;
      r_active  <= '0;
      r_pending <= 1'b0;
    end else begin
      if (i_wr) begin
        r_shadow <= i_wr_data;
      end
      // A write landing on a load edge bypasses the shadow so it is never lost.
      if (i_load) begin
        r_active  <= i_wr ? i_wr_data : r_shadow;
        r_pending <= 1'b0;
      end else if (i_wr) begin
        r_pending <= 1'b1;
      end
    end
  end

  assign o_pending = r_pending;
  assign o_pwm     = i_run & (i_tcr < r_active);

endmodule
`default_nettype wire

// File: rtl/pwm_ccr_bank.sv
`default_nettype none
// ============================================================================
// Module : pwm_ccr_bank
// Shared edge/center-aligned timer driving a bank of buffered compare channels.
// Rev    : 1.0
// ============================================================================
module pwm_ccr_bank
  import pwm_pkg::*;
#(
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int CHANNELS = DEF_CHANNELS,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                center_mode,
  input  logic [WIDTH-1:0]    period_in,
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [WIDTH-1:0]    wr_data,
  output logic [WIDTH-1:0]    tcr_out,
  output logic                update,
  output logic [CHANNELS-1:0] pending,
  output logic [CHANNELS-1:0] pwm_out
);

  logic [WIDTH-1:0] r_tcr;
  logic [WIDTH-1:0] r_period_sh;
  logic [WIDTH-1:0] r_period_act;
  logic             r_mode;
  logic             r_run;
  logic             r_update;
  dir_e             r_dir;

  logic [WIDTH-1:0] w_tcr_step;
  dir_e             w_dir_next;
  logic             w_at_top;
  logic             w_wrap;
  logic             w_event;
  logic             w_load;

  // Next count and direction; a step that lands on 0 is the update event.
  always_comb begin
    w_tcr_step = '0;
    w_dir_next = r_dir;
    w_at_top   = (r_tcr >= r_period_act);
    if (r_mode == MODE_EDGE) begin
      w_tcr_step = w_at_top ? '0 : r_tcr + 1'b1;
      w_dir_next = DIR_UP;
    end else begin
      case (r_dir)
        DIR_UP: begin
          if (w_at_top) begin
            w_tcr_step = (r_period_act == '0) ? '0 : r_period_act - 1'b1;
            w_dir_next = DIR_DOWN;
          end else begin
            w_tcr_step = r_tcr + 1'b1;
          end
        end
        DIR_DOWN: begin
          w_tcr_step = (r_tcr == '0) ? '0 : r_tcr - 1'b1;
        end
        default: begin
          w_tcr_step = '0;
          w_dir_next = DIR_UP;
        end
      endcase
    end
    w_wrap  = (w_tcr_step == '0);
    // Leaving the parked state starts a fresh period exactly like a wrap.
    w_event = ~r_run | w_wrap;
    if (w_event) begin
      w_dir_next = DIR_UP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      r_dir <= DIR_UP;
    end else begin
      r_dir <= w_dir_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tcr        <= '0;
      r_period_sh  <= '0;
      r_period_act <= '0;
      r_mode       <= MODE_EDGE;
      r_run        <= 1'b0;
      r_update     <= 1'b0;
    end else begin
      r_period_sh <= period_in;
      if (!enable) begin
        r_tcr        <= '0;
        r_run        <= 1'b0;
        r_update     <= 1'b0;
        r_period_act <= r_period_sh;
        r_mode       <= center_mode;
      end else begin
        r_run    <= 1'b1;
        r_update <= w_event;
        if (w_event) begin
          r_tcr        <= '0;
          r_period_act <= r_period_sh;
          r_mode       <= center_mode;
        end else begin
          r_tcr <= w_tcr_step;
        end
      end
    end
  end

  // While parked the active registers follow the shadows every cycle.
  assign w_load = ~enable | w_event;

  // Out-of-range channel indices match no instance and are dropped.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    pwm_ccr_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .i_run     (r_run),
      .i_tcr     (r_tcr),
      .i_load    (w_load),
      .i_wr      (wr_en && (wr_ch == CH_W'(c))),
      .i_wr_data (wr_data),
      .o_pending (pending[c]),
      .o_pwm     (pwm_out[c])
    );
  end

  assign tcr_out = r_tcr;
  assign update  = r_update;

endmodule
`default_nettype wire

// File: tb/tb_pwm_ccr_bank.sv
`default_nettype none
// ============================================================================
// Module : tb_pwm_ccr_bank
// Scoreboard bench: period-position reference model versus pwm_ccr_bank.
// Rev    : 1.0
// ============================================================================
module tb_pwm_ccr_bank;
  import pwm_pkg::*;

  localparam int W  = 7;
  localparam int CH = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          center_mode = 1'b0;
  logic [W-1:0]  period_in = '0;
  logic          wr_en = 1'b0;
  logic [0:0]    wr_ch = '0;
  logic [W-1:0]  wr_data = '0;
  logic [W-1:0]  tcr_out;
  logic          update;
  logic [CH-1:0] pending;
  logic [CH-1:0] pwm_out;

  pwm_ccr_bank #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk(clk), .rst(rst), .enable(enable), .center_mode(center_mode),
    .period_in(period_in), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
    .tcr_out(tcr_out), .update(update), .pending(pending), .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  tcr;
    logic          upd;
    logic [CH-1:0] pend;
    logic [CH-1:0] pwm;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  bit   started = 0;

  // Reference model: position k inside the current period plus buffered values.
  bit m_run = 0;
  int m_k = 0, m_p = 0, m_psh = 0;
  bit m_center = 0;
  int m_sh[CH], m_act[CH];
  bit m_pend[CH];

  function automatic int period_len(int p, bit ctr);
    if (ctr) return (p == 0) ? 1 : 2 * p;
    return p + 1;
  endfunction

  function automatic int tcr_at(int k, int p, bit ctr);
    if (!ctr || k <= p) return k;
    return 2 * p - k;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp_v);
    end
  endtask

  always @(posedge clk) begin : p_model
    exp_t e;
    bit   ev;
    bit   hit;
    int   t;
    ev = 0;
    if (rst) begin
      m_run = 0; m_k = 0; m_p = 0; m_psh = 0; m_center = 0;
      for (int c = 0; c < CH; c++) begin
        m_sh[c] = 0; m_act[c] = 0; m_pend[c] = 0;
      end
    end else begin
      if (enable) ev = !m_run || (m_k == period_len(m_p, m_center) - 1);
      for (int c = 0; c < CH; c++) begin
        hit = wr_en && (int'(wr_ch) == c);
        if (hit) m_sh[c] = int'(wr_data);
        if (!enable || ev) begin
          m_act[c]  = m_sh[c];
          m_pend[c] = 0;
        end else if (hit) begin
          m_pend[c] = 1;
        end
      end
      if (!enable || ev) begin
        m_k = 0;
        m_p = m_psh;
        m_center = center_mode;
      end else begin
        m_k++;
      end
      m_run = enable;
      m_psh = int'(period_in);
    end
    t = m_run ? tcr_at(m_k, m_p, m_center) : 0;
    e.tcr = W'(t);
    e.upd = ev;
    for (int c = 0; c < CH; c++) begin
      e.pend[c] = m_pend[c];
      e.pwm[c]  = m_run && (t < m_act[c]);
    end
    q.push_back(e);
    started = 1;
  end

  always @(negedge clk) begin : p_monitor
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("tcr_out", 32'(tcr_out), 32'(e.tcr));
      chk("update", 32'(update), 32'(e.upd));
      chk("pending", 32'(pending), 32'(e.pend));
      chk("pwm_out", 32'(pwm_out), 32'(e.pwm));
    end else if (started) begin
      chk("scoreboard_starved", 32'd1, 32'd0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write(input int ch, input int d);
    wr_en = 1'b1; wr_ch = 1'(ch); wr_data = W'(d);
    cyc(1);
    wr_en = 1'b0;
  endtask

  task automatic wait_tcr(input int val, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (m_run && tcr_at(m_k, m_p, m_center) == val) return;
      cyc(1);
    end
    chk("wait_tcr_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_last(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (m_run && m_k == period_len(m_p, m_center) - 1) return;
      cyc(1);
    end
    chk("wait_wrap_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    cyc(2);
    rst = 1'b0; enable = 1'b1; period_in = '0;
    cyc(6);
    period_in = W'(9);
    write(0, 3);
    write(1, 10);
    cyc(40);
    wait_tcr(4, 100);
    write(0, 7);
    cyc(25);
    wait_last(100);
    write(0, 5);
    cyc(25);
    center_mode = 1'b1; period_in = W'(8);
    write(0, 3);
    cyc(60);
    wait_tcr(5, 100);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(19);
    enable = 1'b0;
    write(0, 2);
    period_in = W'(6);
    cyc(4);
    enable = 1'b1;
    cyc(30);
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 399) == 0);
      if (enable) begin
        if ($urandom_range(0, 49) == 0) enable = 1'b0;
      end else if ($urandom_range(0, 4) == 0) begin
        enable = 1'b1;
      end
      if ($urandom_range(0, 39) == 0) center_mode = ~center_mode;
      if ($urandom_range(0, 29) == 0) period_in = W'($urandom_range(0, 12));
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_ch   = 1'($urandom_range(0, 1));
      wr_data = W'($urandom_range(0, 15));
      cyc(1);
    end
    rst = 1'b0; wr_en = 1'b0;
    cyc(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
